// File: rtl/bkg_pkg.sv
// Shared definitions for the background tile map controller.
// Holds the map geometry, tile code constants, FSM state encoding and a
// small address range helper used by the controller and the tile RAM.
package bkg_pkg;

  localparam int MAP_W = 20;
  localparam int MAP_H = 15;
  localparam int DEPTH = MAP_W * MAP_H;
  localparam int AW    = 9;
  localparam int DW    = 3;

  localparam logic [AW-1:0] DEPTH_ADDR = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

  localparam logic [DW-1:0] TILE_FLOOR = 3'd0;
  localparam logic [DW-1:0] TILE_BLOCK = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } bkg_state_e;

  // True when a linear address falls inside the 20x15 map.
  function automatic logic addr_in_map(input logic [AW-1:0] addr);
    return addr < DEPTH_ADDR;
  endfunction

endpackage

// File: rtl/bkg_map_ctrl_if.sv
// Requester bus for the tile map: a read-only VGA fetch channel and a
// read/write game logic channel.
//   master : requester side (drives req/addr/we/wdata, receives data/valid/grant)
//   slave  : controller side
interface bkg_map_ctrl_if;
  import bkg_pkg::*;

  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_q;
  logic          vga_valid;

  logic          game_req;
  logic          game_we;
  logic [AW-1:0] game_addr;
  logic [DW-1:0] game_wdata;
  logic          game_gnt;
  logic [DW-1:0] game_rdata;
  logic          game_rvalid;

  modport master (
    output vga_req, vga_addr, game_req, game_we, game_addr, game_wdata,
    input  vga_q, vga_valid, game_gnt, game_rdata, game_rvalid
  );

  modport slave (
    input  vga_req, vga_addr, game_req, game_we, game_addr, game_wdata,
    output vga_q, vga_valid, game_gnt, game_rdata, game_rvalid
  );

endinterface

// File: rtl/bkg_tile_ram.sv
// Single-port DEPTH x DW tile RAM with synchronous write and registered read.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (read register only)
//   en, we     : access enable and write select
//   addr       : linear tile address
//   wdata      : tile code to write
//   rdata      : registered read data, held until the next read
// Out-of-map addresses read as 0 and ignore writes.
module bkg_tile_ram
  import bkg_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = addr_in_map(addr) ? mem[addr] : '0;
    end
  end

  // Array contents are deliberately not reset; the map is undefined until loaded.
  always_ff @(posedge clk) begin
    if (en && we && addr_in_map(addr)) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bkg_map_ctrl.sv
// Background tile map controller: copies the level image from the
// background ROM into the tile RAM on load_start, then shares the RAM between
// the VGA fetch (absolute priority) and game logic.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   load_start   : one-cycle pulse requesting a (re)load from ROM
//   load_busy    : high while copying
//   load_done    : one-cycle pulse after the last entry is written
//   rom_addr     : address to the combinational background ROM
//   rom_q        : ROM data for rom_addr
//   bus          : VGA and game requester channels (slave side)
module bkg_map_ctrl
  import bkg_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  output logic          load_busy,
  output logic          load_done,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q,
  bkg_map_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_SERVE = ST_SERVE;

  logic [1:0]    state_d, state_q;
  logic [AW-1:0] cnt_d, cnt_q;
  logic          load_done_d, load_done_q;
  logic          vga_valid_d, vga_valid_q;
  logic          vga_from_ram_d, vga_from_ram_q;
  logic          game_rvalid_d, game_rvalid_q;
  logic [DW-1:0] vga_hold_d, vga_hold_q;
  logic [DW-1:0] game_hold_d, game_hold_q;

  logic          serve_ok;
  logic          game_gnt;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [DW-1:0] vga_q_now, game_rdata_now;

  bkg_tile_ram u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM has one read register shared by both channels, so each channel
  // keeps its own copy of the last returned value. VGA reads accepted outside
  // SERVE never touch the RAM and return 0.
  always_comb begin
    vga_q_now      = vga_valid_q ? (vga_from_ram_q ? ram_rdata : '0) : vga_hold_q;
    game_rdata_now = game_rvalid_q ? ram_rdata : game_hold_q;
  end

  // A load_start seen in SERVE takes the RAM port away for that cycle.
  always_comb begin
    serve_ok = (state_q == S_SERVE) && !load_start;
    game_gnt = bus.game_req && !bus.vga_req && serve_ok;

    state_d        = state_q;
    cnt_d          = cnt_q;
    load_done_d    = 1'b0;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = '0;
    ram_wdata      = '0;

    case (state_q)
      S_LOAD: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = cnt_q;
        ram_wdata = rom_q;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d     = S_SERVE;
          cnt_d       = '0;
          load_done_d = 1'b1;
        end
      end
      S_SERVE: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (bus.vga_req) begin
          ram_en   = 1'b1;
          ram_addr = bus.vga_addr;
        end else if (game_gnt) begin
          ram_en    = 1'b1;
          ram_we    = bus.game_we;
          ram_addr  = bus.game_addr;
          ram_wdata = bus.game_wdata;
        end
      end
      default: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
    endcase

    vga_valid_d    = bus.vga_req;
    vga_from_ram_d = bus.vga_req && serve_ok;
    game_rvalid_d  = game_gnt && !bus.game_we;
    vga_hold_d     = vga_q_now;
    game_hold_d    = game_rdata_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      load_done_q    <= 1'b0;
      vga_valid_q    <= 1'b0;
      vga_from_ram_q <= 1'b0;
      game_rvalid_q  <= 1'b0;
      vga_hold_q     <= '0;
      game_hold_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      load_done_q    <= load_done_d;
      vga_valid_q    <= vga_valid_d;
      vga_from_ram_q <= vga_from_ram_d;
      game_rvalid_q  <= game_rvalid_d;
      vga_hold_q     <= vga_hold_d;
      game_hold_q    <= game_hold_d;
    end
  end

  assign load_busy       = (state_q == S_LOAD);
  assign load_done       = load_done_q;
  assign rom_addr        = cnt_q;
  assign bus.vga_q       = vga_q_now;
  assign bus.vga_valid   = vga_valid_q;
  assign bus.game_gnt    = game_gnt;
  assign bus.game_rdata  = game_rdata_now;
  assign bus.game_rvalid = game_rvalid_q;

endmodule

// File: tb/tb_bkg_map_ctrl.sv
// Testbench for bkg_map_ctrl: a ROM image plus a tile-map reference model
// predict every response; reads push expected data into per-channel queues
// and an independent monitor pops and compares when the DUT presents data.
module tb_bkg_map_ctrl;
  import bkg_pkg::*;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_SERVE = 2;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          load_busy;
  logic          load_done;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;

  bkg_map_ctrl_if bus ();

  bkg_map_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom_img [DEPTH];
  logic [DW-1:0] ref_map [DEPTH];

  assign rom_q = (int'(rom_addr) < DEPTH) ? rom_img[rom_addr] : '0;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   mode = M_IDLE;
  int   ld_idx = 0;
  bit   done_exp = 1'b0;
  logic [DW-1:0] last_vga = '0;
  logic [DW-1:0] last_game = '0;
  exp_t vga_exp[$];
  exp_t game_exp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] refRead(input int addr);
    return (addr < DEPTH) ? ref_map[addr] : '0;
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (vga_exp.size() > 0 && vga_exp[0].due == cyc) begin
        e = vga_exp.pop_front();
        checkOutput("vga_valid", bus.vga_valid, 1);
        checkOutput("vga_q", bus.vga_q, e.data);
        last_vga = e.data;
      end else begin
        checkOutput("vga_valid_idle", bus.vga_valid, 0);
        checkOutput("vga_q_hold", bus.vga_q, last_vga);
      end
      if (game_exp.size() > 0 && game_exp[0].due == cyc) begin
        e = game_exp.pop_front();
        checkOutput("game_rvalid", bus.game_rvalid, 1);
        checkOutput("game_rdata", bus.game_rdata, e.data);
        last_game = e.data;
      end else begin
        checkOutput("game_rvalid_idle", bus.game_rvalid, 0);
        checkOutput("game_rdata_hold", bus.game_rdata, last_game);
      end
    end
  end

  // One clock of stimulus, entered and left at posedge+1. Expected responses
  // are derived from the map model, then the model advances by one cycle.
  task automatic applyStimulus(input bit ls, input bit vreq, input int vaddr,
                               input bit greq, input bit gwe, input int gaddr,
                               input logic [DW-1:0] gwd);
    bit   exp_gnt;
    bit   serving;
    bit   done_next;
    exp_t e;
    load_start     = ls;
    bus.vga_req    = vreq;
    bus.vga_addr   = AW'(vaddr);
    bus.game_req   = greq;
    bus.game_we    = gwe;
    bus.game_addr  = AW'(gaddr);
    bus.game_wdata = gwd;

    serving = (mode == M_SERVE) && !ls;
    exp_gnt = greq && !vreq && serving;
    if (vreq) begin
      e.data = serving ? refRead(vaddr) : '0;
      e.due  = cyc + 1;
      vga_exp.push_back(e);
    end
    if (exp_gnt && !gwe) begin
      e.data = refRead(gaddr);
      e.due  = cyc + 1;
      game_exp.push_back(e);
    end
    if (exp_gnt && gwe && gaddr < DEPTH) ref_map[gaddr] = gwd;

    @(negedge clk);
    checkOutput("game_gnt", bus.game_gnt, exp_gnt);
    checkOutput("load_busy", load_busy, (mode == M_LOAD));
    checkOutput("rom_addr", rom_addr, (mode == M_LOAD) ? ld_idx : 0);
    checkOutput("load_done", load_done, done_exp);

    @(posedge clk);
    #1;
    done_next = 1'b0;
    if (mode == M_LOAD) begin
      ref_map[ld_idx] = rom_img[ld_idx];
      ld_idx++;
      if (ld_idx == DEPTH) begin
        mode      = M_SERVE;
        ld_idx    = 0;
        done_next = 1'b1;
      end
    end else if (ls) begin
      mode   = M_LOAD;
      ld_idx = 0;
    end
    done_exp = done_next;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, '0);
  endtask

  // Full load with random VGA/game traffic; one load_start mid-way must be ignored.
  task automatic fullLoad(input int ignored_at);
    applyStimulus(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(i == ignored_at, ($urandom_range(0, 3) == 0), $urandom_range(0, 319),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 319),
                    DW'($urandom_range(0, 7)));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_load_busy"}, load_busy, 0);
    checkOutput({tag, "_load_done"}, load_done, 0);
    checkOutput({tag, "_rom_addr"}, rom_addr, 0);
    checkOutput({tag, "_vga_valid"}, bus.vga_valid, 0);
    checkOutput({tag, "_vga_q"}, bus.vga_q, 0);
    checkOutput({tag, "_game_gnt"}, bus.game_gnt, 0);
    checkOutput({tag, "_game_rvalid"}, bus.game_rvalid, 0);
    checkOutput({tag, "_game_rdata"}, bus.game_rdata, 0);
  endtask

  task automatic resetModel();
    vga_exp.delete();
    game_exp.delete();
    mode      = M_IDLE;
    ld_idx    = 0;
    done_exp  = 1'b0;
    last_vga  = '0;
    last_game = '0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_img[i] = DW'($urandom_range(0, 7));
    rom_img[82] = TILE_BLOCK;
    rom_img[83] = TILE_FLOOR;
    rom_img[84] = TILE_BLOCK;

    bus.vga_req = 0; bus.vga_addr = '0; bus.game_req = 1; bus.game_we = 0;
    bus.game_addr = '0; bus.game_wdata = '0;
    #12;
    checkResetOutputs("reset");
    bus.game_req = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    resetModel();
    mon_en = 1'b1;

    $display("[TB] initial load with ignored load_start at cnt 150");
    fullLoad(150);
    applyStimulus(0, 1, 82, 0, 0, 0, '0);
    applyStimulus(0, 1, 83, 0, 0, 0, '0);

    $display("[TB] arbitration");
    applyStimulus(0, 1, 10, 1, 0, 20, '0);
    applyStimulus(0, 0, 0, 1, 0, 20, '0);
    idleCycle();

    $display("[TB] game write then reads");
    applyStimulus(0, 0, 0, 1, 1, 82, TILE_FLOOR);
    applyStimulus(0, 1, 82, 0, 0, 0, '0);
    applyStimulus(0, 1, 84, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, 82, '0);

    $display("[TB] out-of-map accesses");
    applyStimulus(0, 0, 0, 1, 1, 300, TILE_BLOCK);
    applyStimulus(0, 0, 0, 1, 0, 300, '0);
    applyStimulus(0, 1, 300, 0, 0, 0, '0);
    applyStimulus(0, 1, 299, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, 511, '0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(0, $urandom_range(0, 1), $urandom_range(0, 319),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 319),
                    DW'($urandom_range(0, 7)));
    end

    $display("[TB] reload from SERVE");
    applyStimulus(0, 0, 0, 1, 1, 82, TILE_FLOOR);
    applyStimulus(1, 0, 0, 1, 1, 83, 3'd7);
    for (int i = 0; i < DEPTH; i++) idleCycle();
    applyStimulus(0, 1, 82, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, 83, '0);

    $display("[TB] reset in the middle of a load");
    applyStimulus(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 100; i++) idleCycle();
    mon_en = 1'b0;
    bus.game_req = 1;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    resetModel();
    #14;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, $urandom_range(0, 299), 1, $urandom_range(0, 1),
                    $urandom_range(0, 299), DW'($urandom_range(0, 7)));
    end
    fullLoad(-1);
    applyStimulus(0, 1, 82, 0, 0, 0, '0);
    applyStimulus(0, 1, 83, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, 84, '0);
    idleCycle();
    idleCycle();

    checkOutput("vga_queue_drained", vga_exp.size(), 0);
    checkOutput("game_queue_drained", game_exp.size(), 0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
